rom_arbiter: RTL and testbench

Two-port arbiter that shares the single combinational-read instruction ROM (10-bit word address, 32-bit data) between the CPU fetch stage and a secondary reader, such as the debug/display readback path. Fetch has priority, but a starvation limit guarantees the secondary port a slot. The arbiter drives the ROM address, registers the returned word, and returns it to the granted port one cycle later. It also keeps saturating per-port grant counters for performance inspection.

---
 rtl/rom_arbiter.sv | 122 ++++++++++++
 tb/tb_rom_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - fetch/secondary arbiter for a shared combinational instruction ROM
module rom_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [CNT_W-1:0]  f_cnt,
  output logic [CNT_W-1:0]  d_cnt
);

  // Wait counter only has to reach MAX_WAIT; keep at least one bit so MAX_WAIT=0 still elaborates.
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              f_rvalid_q, f_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  f_cnt_q, f_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

  // Fetch wins contention unless the secondary port has been starved for MAX_WAIT cycles.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (f_req && d_req) begin
      if (wait_q >= WAIT_LIMIT) begin
        d_gnt = 1'b1;
      end else begin
        f_gnt = 1'b1;
      end
    end else if (f_req) begin
      f_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end
  end

  // ROM address follows the winner; when idle it parks on the last granted address.
  always_comb begin
    rom_addr = addr_hold_q;
    if (f_gnt) begin
      rom_addr = f_addr;
    end else if (d_gnt) begin
      rom_addr = d_addr;
    end
  end

  // Next-state: read capture, starvation tracking and saturating grant counters.
  always_comb begin
    addr_hold_d = rom_addr;
    f_rvalid_d  = f_gnt;
    d_rvalid_d  = d_gnt;
    f_rdata_d   = f_gnt ? rom_data : f_rdata_q;
    d_rdata_d   = d_gnt ? rom_data : d_rdata_q;

    wait_d = wait_q;
    if (d_gnt || !d_req) begin
      wait_d = '0;
    end else if (wait_q < WAIT_LIMIT) begin
      wait_d = wait_q + 1'b1;
    end

    f_cnt_d = f_cnt_q;
    if (f_gnt && (f_cnt_q != CNT_MAX)) begin
      f_cnt_d = f_cnt_q + 1'b1;
    end
    d_cnt_d = d_cnt_q;
    if (d_gnt && (d_cnt_q != CNT_MAX)) begin
      d_cnt_d = d_cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any grant made in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q      <= '0;
      addr_hold_q <= '0;
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      f_cnt_q     <= '0;
      d_cnt_q     <= '0;
    end else begin
      wait_q      <= wait_d;
      addr_hold_q <= addr_hold_d;
      f_rvalid_q  <= f_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_cnt_q     <= f_cnt_d;
      d_cnt_q     <= d_cnt_d;
    end
  end

  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign f_cnt    = f_cnt_q;
  assign d_cnt    = d_cnt_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - vector table plus scoreboard bench for rom_arbiter
module tb_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req, d_req;
  logic [9:0]  f_addr, d_addr;

  logic        f_gnt, d_gnt, f_rvalid, d_rvalid;
  logic [31:0] f_rdata, d_rdata, rom_data;
  logic [9:0]  rom_addr;
  logic [15:0] f_cnt, d_cnt;

  logic        s_f_gnt, s_d_gnt, s_f_rvalid, s_d_rvalid;
  logic [31:0] s_f_rdata, s_d_rdata, s_rom_data;
  logic [9:0]  s_rom_addr;
  logic [3:0]  s_f_cnt, s_d_cnt;

  logic        z_f_gnt, z_d_gnt, z_f_rvalid, z_d_rvalid;
  logic [31:0] z_f_rdata, z_d_rdata, z_rom_data;
  logic [9:0]  z_rom_addr;
  logic [15:0] z_f_cnt, z_d_cnt;

  function automatic logic [31:0] rom_fn(input logic [9:0] a);
    if (a == 10'h005) return 32'h2008000A;
    return {a, ~a, 12'hA5C};
  endfunction

  assign rom_data   = rom_fn(rom_addr);
  assign s_rom_data = rom_fn(s_rom_addr);
  assign z_rom_data = rom_fn(z_rom_addr);

  rom_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rom_addr(rom_addr), .rom_data(rom_data), .f_cnt(f_cnt), .d_cnt(d_cnt)
  );

  rom_arbiter #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(s_f_gnt), .f_rvalid(s_f_rvalid), .f_rdata(s_f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data), .f_cnt(s_f_cnt), .d_cnt(s_d_cnt)
  );

  rom_arbiter #(.MAX_WAIT(0)) dut_z (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(z_f_gnt), .f_rvalid(z_f_rvalid), .f_rdata(z_f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
    .rom_addr(z_rom_addr), .rom_data(z_rom_data), .f_cnt(z_f_cnt), .d_cnt(z_d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fr;
    logic [9:0] fa;
    logic       dr;
    logic [9:0] da;
    logic       efg;
    logic       edg;
  } vec_t;

  typedef struct {
    logic        fv;
    logic        dv;
    logic [31:0] fd;
    logic [31:0] dd;
    logic [15:0] fc;
    logic [15:0] dc;
    logic [3:0]  fcs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_frd, m_drd;
  logic [15:0] m_fc, m_dc;
  logic [3:0]  m_fcs;
  logic [9:0]  m_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frd = '0; m_drd = '0; m_fc = '0; m_dc = '0; m_fcs = '0; m_hold = '0;
  endtask

  // One clock: drive inputs, check grants/address, push expected response, pop and compare it.
  task automatic step(input logic r, input logic fr, input logic [9:0] fa,
                      input logic dr, input logic [9:0] da,
                      input logic efg, input logic edg);
    exp_t e;
    @(negedge clk);
    rst = r; f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
    #1;
    if (!r) begin
      chk("f_gnt", {31'd0, f_gnt}, {31'd0, efg});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
      chk("rom_addr", {22'd0, rom_addr}, {22'd0, efg ? fa : (edg ? da : m_hold)});
      chk("z_d_gnt", {31'd0, z_d_gnt}, {31'd0, dr});
      chk("z_f_gnt", {31'd0, z_f_gnt}, {31'd0, fr & ~dr});
    end
    if (r) begin
      model_reset();
      e = '{fv: 1'b0, dv: 1'b0, fd: '0, dd: '0, fc: '0, dc: '0, fcs: '0};
    end else begin
      if (efg) begin
        m_frd = rom_fn(fa); m_hold = fa;
        if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        if (m_fcs != 4'hF) m_fcs = m_fcs + 4'd1;
      end
      if (edg) begin
        m_drd = rom_fn(da); m_hold = da;
        if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
      end
      e = '{fv: efg, dv: edg, fd: m_frd, dd: m_drd, fc: m_fc, dc: m_dc, fcs: m_fcs};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, e.fv});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.dv});
    chk("f_rdata", f_rdata, e.fd);
    chk("d_rdata", d_rdata, e.dd);
    chk("f_cnt", {16'd0, f_cnt}, {16'd0, e.fc});
    chk("d_cnt", {16'd0, d_cnt}, {16'd0, e.dc});
    chk("s_f_cnt", {28'd0, s_f_cnt}, {28'd0, e.fcs});
    chk("s_f_rdata", s_f_rdata, e.fd);
  endtask

  task automatic add(input logic fr, input logic [9:0] fa, input logic dr, input logic [9:0] da,
                     input logic efg, input logic edg);
    vecs.push_back('{fr: fr, fa: fa, dr: dr, da: da, efg: efg, edg: edg});
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
    model_reset();

    // idle, single fetch, park, secondary only
    add(0, 10'h000, 0, 10'h000, 0, 0);
    add(1, 10'h005, 0, 10'h000, 1, 0);
    add(0, 10'h000, 0, 10'h000, 0, 0);
    add(0, 10'h000, 1, 10'h123, 0, 1);
    // ten cycles of contention: d wins on cycles 5 and 10
    for (int i = 0; i < 10; i++) begin
      add(1, 10'(16 + i), 1, (i < 5) ? 10'h200 : 10'h201, (i != 4) && (i != 9), (i == 4) || (i == 9));
    end
    // secondary denied twice, abandons, then waits the full four cycles again
    add(1, 10'h030, 1, 10'h300, 1, 0);
    add(1, 10'h031, 1, 10'h300, 1, 0);
    add(1, 10'h032, 0, 10'h000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      add(1, 10'(64 + i), 1, 10'h3A0, i != 4, i == 4);
    end
    add(0, 10'h000, 0, 10'h000, 0, 0);

    step(1, 0, '0, 0, '0, 0, 0);
    step(1, 0, '0, 0, '0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].da, vecs[i].efg, vecs[i].edg);
    end

    // reset while a fetch is being granted: no response, everything cleared
    step(1, 1, 10'h007, 0, '0, 0, 0);
    step(0, 0, '0, 0, '0, 0, 0);

    // 20 back-to-back fetches: 4-bit counter saturates at 15, data stays correct
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 10'(i * 3 + 1), 0, '0, 1, 0);
    end
    step(0, 0, '0, 0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
